// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
// Arbitrates three requesters (resend, classification result, training ack)
// for one UART transmitter. Each grant becomes a 5-byte frame:
//   START(ff) TYPE PAYLOAD CHECKSUM STOP(bb)
// Bytes go to the shifter one at a time with a tx_start/tx_done handshake.
// A per-byte timeout drops the frame if tx_done never comes.
//
// Ports
//   uart_sampling_clk  clock, rising edge
//   rst                asynchronous active-high reset
//   resend_req         pulse, host must resend last packet
//   result_req         pulse, classification result ready
//   result_label[7:0]  label, valid with result_req
//   ack_req            pulse, training packet accepted
//   overrun_clr        synchronous clear of overrun
//   tx_done            pulse, current byte fully shifted out
//   tx_start           pulse, transmitter loads tx_byte
//   tx_byte[7:0]       byte to send, stable until tx_done or abort
//   busy               frame in progress
//   frame_done         pulse after STOP byte's tx_done
//   tx_timeout         pulse when a frame is aborted
//   overrun            sticky, request arrived while same type pending
module uart_tx_scheduler #(
    parameter int unsigned TIMEOUT = 2000
) (
    input  logic       uart_sampling_clk,
    input  logic       rst,
    input  logic       resend_req,
    input  logic       result_req,
    input  logic [7:0] result_label,
    input  logic       ack_req,
    input  logic       overrun_clr,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       frame_done,
    output logic       tx_timeout,
    output logic       overrun
);

    // Abort fires on the edge where the counter would become TIMEOUT-1.
    localparam logic [16:0] TIMEOUT_LAST = 17'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

    state_e      r_state,      w_state_d;
    logic [2:0]  r_idx,        w_idx_d;
    logic [15:0] r_cnt,        w_cnt_d;
    logic        r_pend_resend, w_pend_resend_d;
    logic        r_pend_result, w_pend_result_d;
    logic        r_pend_ack,    w_pend_ack_d;
    logic [7:0]  r_label,      w_label_d;
    logic [7:0]  r_type,       w_type_d;
    logic [7:0]  r_payload,    w_payload_d;
    logic [7:0]  r_csum,       w_csum_d;
    logic        r_tx_start,   w_tx_start_d;
    logic [7:0]  r_tx_byte,    w_tx_byte_d;
    logic        r_busy,       w_busy_d;
    logic        r_frame_done, w_frame_done_d;
    logic        r_tx_timeout, w_tx_timeout_d;
    logic        r_overrun,    w_overrun_d;

    logic        w_load;
    logic [16:0] w_cnt_inc;

    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;

    always_comb begin
        w_state_d       = r_state;
        w_idx_d         = r_idx;
        w_cnt_d         = r_cnt;
        w_pend_resend_d = r_pend_resend;
        w_pend_result_d = r_pend_result;
        w_pend_ack_d    = r_pend_ack;
        w_type_d        = r_type;
        w_payload_d     = r_payload;
        w_csum_d        = r_csum;
        w_frame_done_d  = 1'b0;
        w_tx_timeout_d  = 1'b0;
        w_load          = 1'b0;

        case (r_state)
            StIdle: begin
                if (r_pend_resend || r_pend_result || r_pend_ack) begin
                    if (r_pend_resend) begin
                        w_pend_resend_d = 1'b0;
                        w_type_d        = 8'hcc;
                        w_payload_d     = 8'h00;
                    end else if (r_pend_result) begin
                        w_pend_result_d = 1'b0;
                        w_type_d        = 8'h0f;
                        w_payload_d     = r_label;
                    end else begin
                        w_pend_ack_d    = 1'b0;
                        w_type_d        = 8'hf0;
                        w_payload_d     = 8'h00;
                    end
                    w_csum_d  = w_type_d + w_payload_d;
                    w_idx_d   = 3'd0;
                    w_state_d = StSend;
                    w_load    = 1'b1;
                end
            end
            StSend: begin
                w_state_d = StWait;
                w_cnt_d   = 16'd0;
            end
            StWait: begin
                // tx_done takes precedence over an expiring counter.
                if (tx_done) begin
                    if (r_idx == 3'd4) begin
                        w_frame_done_d = 1'b1;
                        w_state_d      = StIdle;
                    end else begin
                        w_idx_d   = r_idx + 3'd1;
                        w_state_d = StSend;
                        w_load    = 1'b1;
                    end
                end else if (w_cnt_inc >= TIMEOUT_LAST) begin
                    w_tx_timeout_d = 1'b1;
                    w_state_d      = StIdle;
                end else begin
                    w_cnt_d = w_cnt_inc[15:0];
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // New requests are applied after the grant clear so a request on the
        // grant edge (or during its own frame) re-arms the flag.
        if (resend_req) begin
            w_pend_resend_d = 1'b1;
        end
        if (result_req) begin
            w_pend_result_d = 1'b1;
        end
        if (ack_req) begin
            w_pend_ack_d = 1'b1;
        end
    end

    // Outputs and side registers.
    always_comb begin
        w_label_d = result_req ? result_label : r_label;

        w_overrun_d = r_overrun;
        if (overrun_clr) begin
            w_overrun_d = 1'b0;
        end
        if ((resend_req && r_pend_resend) || (result_req && r_pend_result) ||
            (ack_req && r_pend_ack)) begin
            w_overrun_d = 1'b1;
        end

        w_tx_start_d = w_load;
        w_tx_byte_d  = r_tx_byte;
        if (w_load) begin
            case (w_idx_d)
                3'd0:    w_tx_byte_d = 8'hff;
                3'd1:    w_tx_byte_d = w_type_d;
                3'd2:    w_tx_byte_d = w_payload_d;
                3'd3:    w_tx_byte_d = w_csum_d;
                3'd4:    w_tx_byte_d = 8'hbb;
                default: w_tx_byte_d = 8'h00;
            endcase
        end

        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge uart_sampling_clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_idx         <= 3'd0;
            r_cnt         <= 16'd0;
            r_pend_resend <= 1'b0;
            r_pend_result <= 1'b0;
            r_pend_ack    <= 1'b0;
            r_label       <= 8'h00;
            r_type        <= 8'h00;
            r_payload     <= 8'h00;
            r_csum        <= 8'h00;
            r_tx_start    <= 1'b0;
            r_tx_byte     <= 8'h00;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_tx_timeout  <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_idx         <= w_idx_d;
            r_cnt         <= w_cnt_d;
            r_pend_resend <= w_pend_resend_d;
            r_pend_result <= w_pend_result_d;
            r_pend_ack    <= w_pend_ack_d;
            r_label       <= w_label_d;
            r_type        <= w_type_d;
            r_payload     <= w_payload_d;
            r_csum        <= w_csum_d;
            r_tx_start    <= w_tx_start_d;
            r_tx_byte     <= w_tx_byte_d;
            r_busy        <= w_busy_d;
            r_frame_done  <= w_frame_done_d;
            r_tx_timeout  <= w_tx_timeout_d;
            r_overrun     <= w_overrun_d;
        end
    end

    assign tx_start   = r_tx_start;
    assign tx_byte    = r_tx_byte;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign tx_timeout = r_tx_timeout;
    assign overrun    = r_overrun;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Arbitrates three on-chip requesters for the single UART transmitter: resend-request from the protocol receiver, classification result from the test path, and training ack.
- Sequences each granted request into a 5-byte framed message: START, TYPE, PAYLOAD, CHECKSUM, STOP.
- Drives the transmitter one byte at a time with a start/done handshake and a timeout guard.
- Sits between the receive-side protocol/classifier logic and the UART TX shifter, in the uart_sampling_clk domain.

Parameters:
- TIMEOUT, 2000, cycles to wait for tx_done per byte before aborting the frame; legal range 1..65535.

Ports:
- uart_sampling_clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- resend_req  in  1  one-cycle pulse; the host must resend the last packet.
- result_req  in  1  one-cycle pulse; a classification result is ready.
- result_label  in  8  label; valid in the cycle result_req is high.
- ack_req  in  1  one-cycle pulse; a training packet was accepted.
- overrun_clr  in  1  synchronous clear of overrun.
- tx_done  in  1  pulse from the transmitter when the current byte has fully shifted out.
- tx_start  out  1  one-cycle pulse; the transmitter loads tx_byte.
- tx_byte  out  8  byte to send; held stable from tx_start until tx_done or abort.
- busy  out  1  high while a frame is in progress.
- frame_done  out  1  one-cycle pulse after the STOP byte's tx_done.
- tx_timeout  out  1  one-cycle pulse when a frame is aborted.
- overrun  out  1  sticky; a request arrived while the same type was already pending.

Behaviour:
- Reset (async, any time, including mid-frame):
  - State goes to IDLE.
  - All pending flags, the latched label, the byte index and the timeout counter clear.
  - All outputs are 0; tx_byte is 8'h00.
- Pending capture:
  - Each req pulse sets its pending flag at that edge. result_req also latches result_label into label_q.
  - A req arriving while its flag is already set sets overrun. For result, label_q is overwritten with the newest label.
  - A req arriving during transmission of its own type's frame sets pending again, with no overrun. The frame in flight uses its snapshot.
  - overrun_clr clears overrun. If a set and a clear occur in the same cycle, set wins.
- Arbitration: fixed priority, evaluated only in IDLE: resend > result > ack.
  - On grant at edge E: clear that pending flag.
  - Snapshot TYPE/PAYLOAD:
    - resend: TYPE 8'hcc, PAYLOAD 8'h00.
    - result: TYPE 8'h0f, PAYLOAD label_q.
    - ack: TYPE 8'hf0, PAYLOAD 8'h00.
  - CHECKSUM = (TYPE + PAYLOAD) mod 256. Set idx=0 and go to SEND.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: busy=0. If any pending flag is set, grant and go to SEND.
  - SEND: lasts one cycle. tx_start=1, busy=1, and tx_byte is selected by idx:
    - 0 -> 8'hff
    - 1 -> TYPE
    - 2 -> PAYLOAD
    - 3 -> CHECKSUM
    - 4 -> 8'hbb
    Then go to WAIT and clear the counter.
  - WAIT: busy=1; the counter increments each cycle.
    - tx_done high with idx<4: idx++ and go to SEND.
    - tx_done high with idx==4: frame_done=1 next cycle and go to IDLE.
    - Counter reaches TIMEOUT-1 without tx_done: tx_timeout=1 and go to IDLE. The frame is dropped, not retried; pending flags are untouched.
    - tx_done on the same edge the counter would expire: tx_done wins.
- Latency:
  - A req pulse sampled at edge E0 produces the first tx_start in the cycle after E1, assuming the block is IDLE.
  - Back-to-back frames: IDLE is occupied for exactly one cycle between frame_done and the next tx_start.
- tx_done is ignored in IDLE and SEND.
- All outputs are registered.

Test Plan:
- Single result: result_req with label 8'h07 -> tx_byte sequence ff,0f,07,16,bb, each with one tx_start. frame_done follows the 5th tx_done; tx_start first appears 2 cycles after the req.
- Simultaneous resend_req, result_req (label 8'h03) and ack_req in one cycle -> frames in order: resend (ff,cc,00,cc,bb), result (ff,0f,03,12,bb), ack (ff,f0,00,f0,bb). overrun stays 0.
- Two result_req pulses (labels 8'h01 then 8'h09) while an ack frame is in flight -> overrun=1. A single result frame is sent with payload 09 and checksum 18. overrun_clr then clears it.
- result_req (label 8'h05) during its own frame's WAIT -> current frame completes with label 05. A second result frame with label 05 follows; overrun=0.
- TIMEOUT=8 with no tx_done after the TYPE byte -> tx_timeout pulses exactly 8 cycles after that tx_start cycle. FSM returns to IDLE; busy=0.
- Assert rst in the middle of the PAYLOAD byte's WAIT with resend pending -> immediate outputs 0 and pending cleared. After release, no frame is sent until a new req.
